// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//   Serial boot/program loader. Receives a framed program image on the UART
//   rx line and writes it word by word into instruction memory through the
//   imem program port.
//
//   Frame: 0xA5 | N lo | N hi | N x 4 data bytes (little-endian words) | XOR
//   checksum of the data bytes.
//
//   Optional feature: define UART_PROG_ACK_EN to send a one-byte 8N1
//   acknowledge on tx_o: 0x06 when a frame completes, 0x15 on error.
//   Without it, tx_o is tied high and no transmitter is built.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   rx_i             UART serial input (idle high, asynchronous to clk_i)
//   prog_en_i        1 = loader armed, 0 = loader idle and cleared
//   imem_en_o        imem enable, one-cycle pulse per word
//   imem_prog_ena_o  imem write strobe, asserted together with imem_en_o
//   imem_addr_o      BASE_ADDR + 4 * word index (holds between writes)
//   imem_din_o       assembled word, first received byte in [7:0]
//   busy_o           frame in progress (LEN0..CSUM)
//   done_o           sticky: frame written and checksum matched
//   err_o            sticky: framing, length, checksum error
//   tx_o             acknowledge serial output
// ---------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          MAX_WORDS    = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        prog_en_i,
    output logic        imem_en_o,
    output logic        imem_prog_ena_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_din_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        tx_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   MAX_N     = 17'(MAX_WORDS);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;
    localparam logic [7:0]    ACK_OK    = 8'h06;
    localparam logic [7:0]    ACK_NAK   = 8'h15;

    // ---------------- rx synchroniser + edge history ----------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // ---------------- bit engine ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_byte_q;
    logic          byte_valid_q;
    logic          frame_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    // Falling edge only: a line stuck low after a bad stop bit
                    // must not retrigger the receiver.
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_M1) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // High again at the start-bit centre: treat as a glitch.
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == FULL_M1) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == FULL_M1) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            byte_valid_q <= 1'b1;
                            rx_byte_q    <= rx_shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- frame FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_e;

    state_e      state_q;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;     // lower three bytes; the fourth goes straight out
    logic [7:0]  csum_q;
    logic        imem_en_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        done_q;
    logic        err_q;
    logic        ack_start_q;
    logic [7:0]  ack_byte_q;
    logic        in_frame;

    assign in_frame = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            imem_en_q   <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ack_start_q <= 1'b0;
            ack_byte_q  <= '0;
        end else begin
            imem_en_q   <= 1'b0;
            ack_start_q <= 1'b0;
            if (!prog_en_i) begin
                // Disarm: an already-issued write pulse still completes since
                // imem_en_q is visible this cycle; nothing new is started.
                state_q    <= S_IDLE;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                byte_cnt_q <= '0;
                word_idx_q <= '0;
                csum_q     <= '0;
            end else if (frame_err_q && in_frame) begin
                state_q     <= S_ERROR;
                err_q       <= 1'b1;
                ack_start_q <= 1'b1;
                ack_byte_q  <= ACK_NAK;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_SYNC;
                    S_SYNC: begin
                        if (byte_valid_q && rx_byte_q == SYNC_BYTE) begin
                            state_q    <= S_LEN0;
                            byte_cnt_q <= '0;
                            word_idx_q <= '0;
                            csum_q     <= '0;
                        end
                    end
                    S_LEN0: begin
                        if (byte_valid_q) begin
                            len_lo_q <= rx_byte_q;
                            state_q  <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (byte_valid_q) begin
                            len_q <= {rx_byte_q, len_lo_q};
                            if ({1'b0, rx_byte_q, len_lo_q} > MAX_N) begin
                                state_q     <= S_ERROR;
                                err_q       <= 1'b1;
                                ack_start_q <= 1'b1;
                                ack_byte_q  <= ACK_NAK;
                            end else if ({rx_byte_q, len_lo_q} == 16'd0) begin
                                state_q <= S_CSUM;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_valid_q) begin
                            csum_q     <= csum_q ^ rx_byte_q;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            case (byte_cnt_q)
                                2'd0: word_q[7:0]   <= rx_byte_q;
                                2'd1: word_q[15:8]  <= rx_byte_q;
                                2'd2: word_q[23:16] <= rx_byte_q;
                                default: begin
                                    imem_en_q  <= 1'b1;
                                    addr_q     <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                                    din_q      <= {rx_byte_q, word_q};
                                    word_idx_q <= word_idx_q + 1'b1;
                                    if (word_idx_q == len_q - 16'd1) state_q <= S_CSUM;
                                end
                            endcase
                        end
                    end
                    S_CSUM: begin
                        if (byte_valid_q) begin
                            ack_start_q <= 1'b1;
                            if (rx_byte_q == csum_q) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                ack_byte_q <= ACK_OK;
                            end else begin
                                state_q    <= S_ERROR;
                                err_q      <= 1'b1;
                                ack_byte_q <= ACK_NAK;
                            end
                        end
                    end
                    default: ;  // DONE / ERROR hold until disarmed
                endcase
            end
        end
    end

    assign imem_en_o       = imem_en_q;
    assign imem_prog_ena_o = imem_en_q;
    assign imem_addr_o     = addr_q;
    assign imem_din_o      = din_q;
    assign busy_o          = in_frame && (state_q != S_SYNC);
    assign done_o          = done_q;
    assign err_o           = err_q;

    // ---------------- acknowledge transmitter ----------------
`ifdef UART_PROG_ACK_EN
    logic          tx_q;
    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_shift_q;  // data bits then stop bit, shifted out LSB first

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else if (!tx_busy_q) begin
            // Requests arriving while a byte is on the wire are dropped.
            if (ack_start_q) begin
                tx_busy_q  <= 1'b1;
                tx_q       <= 1'b0;
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
                tx_shift_q <= {1'b1, ack_byte_q};
            end
        end else if (tx_cnt_q == FULL_M1) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
                tx_q      <= 1'b1;
            end else begin
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bit_q   <= tx_bit_q + 1'b1;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    assign tx_o = tx_q;
`else
    logic unused_ack;
    assign unused_ack = ^{ack_start_q, ack_byte_q};
    assign tx_o       = 1'b1;
`endif

endmodule
